ladybird_csr_arbiter: RTL

LADYBIRD_CSR_ARBITER -- requirements
Module: ladybird_csr_arbiter

---
 rtl/ladybird_csr_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ladybird_csr_arbiter.sv
// ladybird_csr_arbiter
//   Arbitrates up to 8 requesters onto a single CSR-file port. Only one access
//   is in flight at a time. Each access takes three states: accept (IDLE),
//   drive the CSR port for one cycle (ISSUE), then hold the response until the
//   granted requester takes it (RESP).
//
//   Build option:
//     LADYBIRD_CSR_ARB_FIXED_PRIO_EN  defined   -> the lowest-index valid
//                                                  requester always wins
//                                     undefined -> round-robin starting at
//                                                  rr_ptr, with wrap-around
//
//   Ports:
//     clk, nrst                      clock, async active-low reset
//     i_req_valid / o_req_ready      per-requester handshake (ready is one-hot)
//     i_req_op/addr/data             packed per-requester funct3, CSR address,
//                                    operand
//     o_rsp_valid / i_rsp_ready      per-requester response handshake
//     o_rsp_data                     CSR value before the access (shared)
//     o_csr_valid/op/addr/data       CSR file command port
//     i_csr_data                     combinational CSR read data
//
//   state | meaning
//   IDLE  | waiting for a request; grant and latch in the same cycle
//   ISSUE | CSR port valid for one cycle; read data captured
//   RESP  | response held to the granted requester until accepted

package ladybird_config;
  localparam int XLEN = 32;
endpackage

module ladybird_csr_arbiter
  import ladybird_config::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [3*N_REQ-1:0]      i_req_op,
  input  logic [12*N_REQ-1:0]     i_req_addr,
  input  logic [XLEN*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [XLEN-1:0]         o_rsp_data,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic                    o_csr_valid,
  output logic [2:0]              o_csr_op,
  output logic [11:0]             o_csr_addr,
  output logic [XLEN-1:0]         o_csr_data,
  input  logic [XLEN-1:0]         i_csr_data
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   g_q;
  logic [GW-1:0]   g_sel;
  logic            any_valid;
  logic            accept;
  logic            rsp_done;
  logic [2:0]      sel_op;
  logic [11:0]     sel_addr;
  logic [XLEN-1:0] sel_data;

  assign any_valid = |i_req_valid;

`ifdef LADYBIRD_CSR_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    g_sel = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req_valid[j]) g_sel = GW'(j);
    end
  end
`else
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] ptr_nxt;
  logic [GW-1:0] g_hi;
  logic [GW-1:0] g_lo;
  logic          found_hi;

  // Round-robin without a rotator: the lowest valid index at or above rr_ptr
  // wins; if there is none the search wraps to the lowest valid index overall.
  always_comb begin
    g_hi     = '0;
    g_lo     = '0;
    found_hi = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req_valid[j]) g_lo = GW'(j);
      if (i_req_valid[j] && (GW'(j) >= rr_ptr)) begin
        g_hi     = GW'(j);
        found_hi = 1'b1;
      end
    end
    g_sel = found_hi ? g_hi : g_lo;
  end

  // With a single requester this is always zero.
  assign ptr_nxt = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr <= '0;
    end else if (rsp_done) begin
      rr_ptr <= ptr_nxt;
    end
  end
`endif

  // Select the granted requester's fields using constant slices only.
  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (g_sel == GW'(j)) begin
        sel_op   = i_req_op[3*j +: 3];
        sel_addr = i_req_addr[12*j +: 12];
        sel_data = i_req_data[XLEN*j +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      g_q        <= '0;
      o_csr_op   <= '0;
      o_csr_addr <= '0;
      o_csr_data <= '0;
      o_rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        g_q        <= g_sel;
        o_csr_op   <= sel_op;
        o_csr_addr <= sel_addr;
        o_csr_data <= sel_data;
      end
      if (state == ISSUE) begin
        o_rsp_data <= i_csr_data;
      end
    end
  end

  // o_req_ready is also gated by nrst: while reset is held the state is IDLE
  // but requests must not appear to be accepted.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    rsp_done    = 1'b0;
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_csr_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
          if (nrst) o_req_ready = N_REQ'(1) << g_sel;
        end
      end
      ISSUE: begin
        o_csr_valid = 1'b1;
        state_nxt   = RESP;
      end
      RESP: begin
        o_rsp_valid = N_REQ'(1) << g_q;
        rsp_done    = |(i_rsp_ready & (N_REQ'(1) << g_q));
        if (rsp_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
